// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell shared over WIDTH cycles, LSB first.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_a, fa_b, fa_s, fa_cout;

    // Gate-level full-adder cell fed from the operand LSBs and the carry flop
    assign fa_a    = a_sh_q[0];
    assign fa_b    = b_sh_q[0];
    assign fa_s    = fa_a ^ fa_b ^ carry_q;
    assign fa_cout = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_d  = 1'b1;
                s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish result; counter parks at zero instead of wrapping
                    cnt_d   = '0;
                    sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Define SERIAL_ADD_OVF_EN for both files to exercise the ovf output.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction observed from E0 through E9 (state back in IDLE).
    // inject: raise start with fresh operands during RUN (sampled at E4) and DONE (E9).
    task automatic do_add(input string tag,
                          input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                          input bit inject, input bit hold_chk, input logic [7:0] old_sum);
        int busy_cnt;
        int done_cnt;
        int done_at;
        bit hold_ok;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        hold_ok  = 1'b1;
        a = ai; b = bi; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (hold_chk && c < 8 && sum !== old_sum) hold_ok = 1'b0;
            if (inject && (c == 3 || c == 8)) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c < 9) tick();
        end
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, ".done_at"}, 32'(done_at), 32'd8);
        chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
        if (hold_chk) chk({tag, ".sum_hold"}, 32'(hold_ok), 32'd1);
    endtask

    initial begin
        int done_seen;
        checks   = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.sum", 32'(sum), 32'd0);
        chk("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("reset.ovf", 32'(ovf), 32'd0);
`endif

        do_add("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        do_add("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        do_add("t3", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        // Issued immediately at E10 of the previous run; must be accepted
        do_add("t4", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46);

        // Reset during RUN aborts and clears the published result
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("t5.busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.sum", 32'(sum), 32'd0);
        chk("t5.cout", 32'(cout), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            tick();
        end
        chk("t5.no_done", 32'(done_seen), 32'd0);
        do_add("t5n", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // rst and start on the same edge: start dropped
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_start.busy", 32'(busy), 32'd0);
        chk("rst_start.sum", 32'(sum), 32'd0);

`ifdef SERIAL_ADD_OVF_EN
        do_add("t6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        do_add("t6b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        do_add("t6c", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
